// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch controller for the LEGv8 core. Owns the program counter,
//   drives the imem word address, and buffers fetched {instruction, PC} pairs
//   in a small FIFO that is handed to decode over a valid/ready handshake.
//   Supports branch redirect/flush (highest priority) and an optional halt
//   when an all-zero instruction word is fetched.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   imem_addr    out  [AW-1:0] word address to imem (= pc[AW+1:2])
//   imem_q       in   [31:0]   combinational imem read data for imem_addr
//   instr        out  [31:0]   FIFO head instruction (0 while empty)
//   instr_pc     out  [N-1:0]  byte PC of instr (0 while empty)
//   instr_valid  out           FIFO non-empty
//   instr_ready  in            decode accepts the head this cycle
//   redirect     in            branch taken / flush request
//   redirect_pc  in   [N-1:0]  new byte PC, valid with redirect
//   halted       out           fetch stopped on a zero word
//   fetch_count  out  [15:0]   words pushed since reset, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int             N            = 64,
  parameter int             AW           = 6,
  parameter int             DEPTH        = 2,
  parameter logic [N-1:0]   RESET_PC     = '0,
  parameter bit             HALT_ON_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [15:0]   fetch_count_q, fetch_count_d;

  // FIFO storage; payload only, so it carries no reset.
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [N-1:0]  fifo_pc_q    [DEPTH];

  logic pop;
  logic full;
  logic fetch_slot;
  logic zero_word;
  logic push;
  logic halt_hit;

  always_comb begin
    pop        = valid_q & instr_ready;
    full       = (count_q == DEPTH_C);
    // A fetch opportunity exists when running, not being redirected, and the
    // FIFO has room now or will have room because the head leaves this edge.
    fetch_slot = (state_q == ST_RUN) & ~redirect & (~full | pop);
    zero_word  = HALT_ON_ZERO && (imem_q == 32'h0000_0000);
    push       = fetch_slot & ~zero_word;
    halt_hit   = fetch_slot & zero_word;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Flush wins over any same-cycle pop or push; low PC bits are dropped.
      state_d  = ST_RUN;
      pc_d     = redirect_pc & ~N'(3);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + N'(4);
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (halt_hit) begin
        state_d = ST_HALT;
      end
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_q;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_addr   = pc_q[AW+1:2];
  assign instr_valid = valid_q;
  assign instr       = valid_q ? fifo_instr_q[rd_ptr_q] : 32'h0000_0000;
  assign instr_pc    = valid_q ? fifo_pc_q[rd_ptr_q] : '0;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule
